// File: rtl/button_tick_conditioner.sv
// Push-button front-end for the countdown timer: synchronizes and debounces three raw
// buttons into single-cycle command pulses, auto-repeats inc, and divides clk down to a tick strobe.
module button_tick_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned TICK_DIV        = 50000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       b0_raw,
   input  logic       b1_raw,
   input  logic       b3_raw,
   output logic       stc,
   output logic       inc,
   output logic       run,
   output logic       tick,
   output logic [2:0] btn_level
);

   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TK_W  = $clog2(TICK_DIV);
   localparam int unsigned R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned R_W   = (R_MAX > 1) ? $clog2(R_MAX) : 1;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
   localparam logic [TK_W-1:0] TK_PRE  = TK_W'(TICK_DIV - 2);
   localparam logic [R_W-1:0]  RD_LAST = R_W'(REPEAT_DELAY - 1);
   localparam logic [R_W-1:0]  RP_LAST = R_W'(REPEAT_PERIOD - 1);

   // Level a raw button shows when it is not pressed.
   localparam logic RELEASED = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

   logic [2:0]      raw_vec;
   logic [2:0]      sync1;
   logic [2:0]      sync2;
   logic [2:0]      p;
   logic [2:0]      s;
   logic [2:0]      s_d;
   logic [2:0]      press;
   logic [2:0]      rise;
   logic [DB_W-1:0] cnt [3];
   rep_state_t      state;
   logic [R_W-1:0]  r;
   logic            rep_q;
   logic [TK_W-1:0] t;

   assign raw_vec = {b3_raw, b1_raw, b0_raw};

   // NOTE: every clocked block uses non-blocking assignments so all flops update
   // from the same pre-edge values and simulation order cannot change the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= {3{RELEASED}};
         sync2 <= {3{RELEASED}};
      end else begin
         sync1 <= raw_vec;
         sync2 <= sync1;
      end
   end

   assign p = BTN_ACTIVE_LOW ? ~sync2 : sync2;

   // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the three counters are plain flops rather than RAM, so they are
         // cleared on reset like any other state; a stale count would fake a press.
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
         s     <= '0;
         s_d   <= '0;
         press <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (p[i] == s[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               s[i]   <= p[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + DB_W'(1);
            end
         end
         s_d   <= s;
         press <= s & ~s_d;
      end
   end

   assign rise      = s & ~s_d;
   assign btn_level = s;

   // Auto-repeat for inc; it arms on the same edge that registers the press pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         r     <= '0;
         rep_q <= 1'b0;
      end else begin
         rep_q <= 1'b0;
         case (state)
            IDLE: begin
               if (rise[1]) begin
                  state <= DELAY;
                  r     <= '0;
               end
            end
            DELAY: begin
               if (!s[1]) begin
                  state <= IDLE;
               end else if (r == RD_LAST) begin
                  rep_q <= 1'b1;
                  state <= REPEAT;
                  r     <= '0;
               end else begin
                  r <= r + R_W'(1);
               end
            end
            REPEAT: begin
               if (!s[1]) begin
                  state <= IDLE;
               end else if (r == RP_LAST) begin
                  rep_q <= 1'b1;
                  r     <= '0;
               end else begin
                  r <= r + R_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // tick is registered one count early so it is high exactly while t == TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         t    <= '0;
         tick <= 1'b0;
      end else begin
         if (t == TK_LAST) t <= '0;
         else              t <= t + TK_W'(1);
         tick <= (t == TK_PRE);
      end
   end

   assign stc = press[0];
   assign inc = press[1] | rep_q;
   assign run = press[2];

endmodule

// File: tb/tb_button_tick_conditioner.sv
// Self-checking bench for button_tick_conditioner: directed vector table, hand-written
// corner sequences and randomized buttons, all compared every cycle against a behavioural model.
module tb_button_tick_conditioner;

   localparam int D  = 4;
   localparam int TD = 10;
   localparam int RD = 20;
   localparam int RP = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       b0_raw, b1_raw, b3_raw;
   logic       stc, inc, run, tick;
   logic [2:0] btn_level;

   button_tick_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .TICK_DIV       (TD),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .BTN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .b0_raw   (b0_raw),
      .b1_raw   (b1_raw),
      .b3_raw   (b3_raw),
      .stc      (stc),
      .inc      (inc),
      .run      (run),
      .tick     (tick),
      .btn_level(btn_level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
   endtask

   // Behavioural model: window-based debounce, press-relative repeat times, tick by modulo.
   bit m_dly  [3][2];
   bit m_win  [3][D];
   int m_wn   [3];
   bit m_s    [3];
   bit m_rose [3];
   bit m_pulse[3];
   int m_n, m_k, m_press_k;
   bit m_armed, m_tick, m_rep;

   int acc_stc, acc_inc, acc_run, acc_tick;

   task automatic model_edge();
      bit raw_now[3];
      bit pdeb, all_diff, new_s;
      int d;
      raw_now[0] = b0_raw;
      raw_now[1] = b1_raw;
      raw_now[2] = b3_raw;
      m_k++;
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            m_dly[b][0] = 1'b0;
            m_dly[b][1] = 1'b0;
            m_wn[b]     = 0;
            m_s[b]      = 1'b0;
            m_rose[b]   = 1'b0;
            m_pulse[b]  = 1'b0;
         end
         m_n = 0; m_armed = 1'b0; m_tick = 1'b0; m_rep = 1'b0;
         return;
      end
      m_n++;
      m_tick = ((m_n % TD) == TD - 1);
      m_rep  = 1'b0;
      if (m_armed) begin
         if (!m_s[1]) begin
            m_armed = 1'b0;
         end else begin
            d = m_k - m_press_k;
            if (d == RD || (d > RD && ((d - RD) % RP) == 0)) m_rep = 1'b1;
         end
      end
      if (m_rose[1]) begin
         m_armed   = 1'b1;
         m_press_k = m_k;
      end
      for (int b = 0; b < 3; b++) begin
         m_pulse[b] = m_rose[b];
         pdeb = m_dly[b][1];
         for (int j = D - 1; j > 0; j--) m_win[b][j] = m_win[b][j-1];
         m_win[b][0] = pdeb;
         if (m_wn[b] < D) m_wn[b]++;
         all_diff = (m_wn[b] == D);
         for (int j = 0; j < D; j++) if (m_win[b][j] == m_s[b]) all_diff = 1'b0;
         new_s      = all_diff ? !m_s[b] : m_s[b];
         m_rose[b]  = new_s && !m_s[b];
         m_s[b]     = new_s;
         m_dly[b][1] = m_dly[b][0];
         m_dly[b][0] = (raw_now[b] == 1'b0);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("stc",       stc,       m_pulse[0]);
      check("inc",       inc,       m_pulse[1] | m_rep);
      check("run",       run,       m_pulse[2]);
      check("tick",      tick,      m_tick);
      check("btn_level", btn_level, {m_s[2], m_s[1], m_s[0]});
      acc_stc  += int'(stc);
      acc_inc  += int'(inc);
      acc_run  += int'(run);
      acc_tick += int'(tick);
   endtask

   task automatic clear_acc();
      acc_stc = 0; acc_inc = 0; acc_run = 0; acc_tick = 0;
   endtask

   typedef struct {
      bit       rst;
      bit       b0, b1, b3;
      int       cycles;
      int       stc_n, inc_n, run_n, tick_n;
      int       first;
      logic [2:0] level;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int   first;
      int   k;
      int   extra;
      int   lvl_seen;
      int   offs[$];
      int   exp_off[5];
      int   got;
      bit   rv[3];
      int   hold[3];

      //            rst b0 b1 b3 cyc stc inc run tick first level
      tbl[0]  = '{1'b1, 1, 1, 1,  3, 0, 0, 0, 0, 0, 3'b000};
      tbl[1]  = '{1'b0, 1, 1, 1, 35, 0, 0, 0, 3, 0, 3'b000};
      tbl[2]  = '{1'b0, 0, 1, 1, 30, 1, 0, 0, 3, 7, 3'b001};
      tbl[3]  = '{1'b0, 1, 1, 1, 10, 0, 0, 0, 1, 0, 3'b000};
      tbl[4]  = '{1'b0, 1, 1, 0, 10, 0, 0, 1, 1, 7, 3'b100};
      tbl[5]  = '{1'b0, 1, 1, 1, 10, 0, 0, 0, 1, 0, 3'b000};
      tbl[6]  = '{1'b0, 0, 1, 0, 10, 1, 0, 1, 1, 7, 3'b101};
      tbl[7]  = '{1'b0, 1, 1, 1, 10, 0, 0, 0, 1, 0, 3'b000};
      tbl[8]  = '{1'b0, 1, 0, 1, 20, 0, 1, 0, 2, 7, 3'b010};
      tbl[9]  = '{1'b1, 1, 0, 1,  1, 0, 0, 0, 0, 0, 3'b000};
      tbl[10] = '{1'b0, 1, 0, 1, 40, 0, 3, 0, 4, 7, 3'b010};
      tbl[11] = '{1'b0, 1, 1, 1, 10, 0, 1, 0, 1, 3, 3'b000};
      tbl[12] = '{1'b0, 1, 1, 1, 20, 0, 0, 0, 2, 0, 3'b000};

      rst = 1'b1; b0_raw = 1'b1; b1_raw = 1'b1; b3_raw = 1'b1;

      for (int i = 0; i < 13; i++) begin
         rst    = tbl[i].rst;
         b0_raw = tbl[i].b0;
         b1_raw = tbl[i].b1;
         b3_raw = tbl[i].b3;
         clear_acc();
         first = 0;
         for (int c = 1; c <= tbl[i].cycles; c++) begin
            cycle();
            if ((stc || inc || run) && first == 0) first = c;
         end
         check($sformatf("vec%0d_stc_count", i),   acc_stc,   tbl[i].stc_n);
         check($sformatf("vec%0d_inc_count", i),   acc_inc,   tbl[i].inc_n);
         check($sformatf("vec%0d_run_count", i),   acc_run,   tbl[i].run_n);
         check($sformatf("vec%0d_tick_count", i),  acc_tick,  tbl[i].tick_n);
         check($sformatf("vec%0d_first_pulse", i), first,     tbl[i].first);
         check($sformatf("vec%0d_level", i),       btn_level, tbl[i].level);
      end

      // Bounce on b3 (2-cycle runs) must never be accepted; a clean press then is.
      clear_acc();
      lvl_seen = 0;
      for (int j = 0; j < 20; j++) begin
         b3_raw = ((j / 2) % 2 == 0) ? 1'b0 : 1'b1;
         cycle();
         if (btn_level[2]) lvl_seen = 1;
      end
      b3_raw = 1'b1;
      for (int j = 0; j < 10; j++) begin
         cycle();
         if (btn_level[2]) lvl_seen = 1;
      end
      check("bounce_run_count", acc_run, 0);
      check("bounce_level_seen", lvl_seen, 0);
      b3_raw = 1'b0;
      for (int j = 0; j < 10; j++) cycle();
      b3_raw = 1'b1;
      for (int j = 0; j < 10; j++) cycle();
      check("clean_run_count", acc_run, 1);

      // Held inc: press pulse at P, repeats at P+20, +28, +36, +44, +52, none after release.
      exp_off = '{20, 28, 36, 44, 52};
      b1_raw = 1'b0;
      k = 0;
      cycle();
      while (!inc && k < 20) begin
         cycle();
         k++;
      end
      check("repeat_press_seen", inc, 1);
      for (int c = 1; c <= 52; c++) begin
         cycle();
         if (inc) offs.push_back(c);
      end
      b1_raw = 1'b1;
      extra = 0;
      for (int c = 0; c < 40; c++) begin
         cycle();
         if (inc) extra++;
      end
      check("repeat_count", offs.size(), 5);
      for (int i = 0; i < 5; i++) begin
         got = (i < offs.size()) ? offs[i] : -1;
         check($sformatf("repeat_offset%0d", i), got, exp_off[i]);
      end
      check("repeat_after_release", extra, 0);

      // Randomized buttons with occasional reset pulses.
      for (int b = 0; b < 3; b++) begin
         rv[b]   = 1'b1;
         hold[b] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (hold[b] == 0) begin
               rv[b]   = 1'($urandom_range(0, 1));
               hold[b] = $urandom_range(1, (b == 1) ? 70 : 25);
            end
            hold[b]--;
         end
         b0_raw = rv[0];
         b1_raw = rv[1];
         b3_raw = rv[2];
         rst    = ($urandom_range(0, 499) == 0);
         cycle();
      end
      rst = 1'b0; b0_raw = 1'b1; b1_raw = 1'b1; b3_raw = 1'b1;
      for (int c = 0; c < 20; c++) cycle();
      check("final_level", btn_level, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
